// File: rtl/retire_queue_pkg.sv
// Shared retire-queue definitions: default sizing, tag/entry types and FSM states.
`ifndef NUM_REG
`define NUM_REG 64
`endif

package retire_queue_pkg;

  localparam int unsigned RQ_DEPTH = 16;
  localparam int unsigned NUM_REG  = `NUM_REG;
  localparam int unsigned RQ_TAG_W = $clog2(RQ_DEPTH);

  typedef logic [RQ_TAG_W-1:0] rq_tag_t;

  // old_preg is held in a separate array so its width can follow PREG_W.
  typedef struct packed {
    logic valid;
    logic done;
    logic has_dst;
    logic is_halt;
  } rq_entry_t;

  typedef enum logic {
    RQ_RUN    = 1'b0,
    RQ_HALTED = 1'b1
  } rq_state_e;

endpackage

// File: rtl/retire_queue.sv
// In-order retire queue: circular buffer of in-flight instructions, retiring the
// head once complete and returning its previous physical mapping to the free list.
module retire_queue
  import retire_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = RQ_DEPTH,
  parameter int unsigned PREG_W = $clog2(NUM_REG),
  localparam int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic              alloc_has_dst,
  input  logic [PREG_W-1:0] alloc_old_preg,
  input  logic              alloc_is_halt,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              done_valid,
  input  logic [TAG_W-1:0]  done_tag,
  input  logic              flush,
  output logic              retire_free,
  output logic [PREG_W-1:0] retire_preg,
  output logic [TAG_W:0]    count,
  output logic              halt
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0] PTR_ONE  = (TAG_W+1)'(1);

  logic [TAG_W:0]    head_q, head_d, tail_q, tail_d;
  rq_entry_t         ent_q  [DEPTH];
  rq_entry_t         ent_d  [DEPTH];
  logic [PREG_W-1:0] preg_q [DEPTH];
  logic [PREG_W-1:0] preg_d [DEPTH];
  rq_state_e         state_q, state_d;
  logic              retire_free_q, retire_free_d;
  logic [PREG_W-1:0] retire_preg_q, retire_preg_d;

  logic [TAG_W-1:0]  head_idx, tail_idx;
  rq_entry_t         head_ent;
  logic              do_alloc, do_retire;

  assign head_idx  = head_q[TAG_W-1:0];
  assign tail_idx  = tail_q[TAG_W-1:0];
  assign head_ent  = ent_q[head_idx];

  assign count       = tail_q - head_q;
  assign alloc_ready = (count != FULL_CNT) && (state_q == RQ_RUN) && !flush;
  assign alloc_tag   = tail_idx;
  assign do_alloc    = alloc_valid && alloc_ready;
  assign do_retire   = head_ent.valid && head_ent.done && (state_q == RQ_RUN) && !flush;

  assign retire_free = retire_free_q;
  assign retire_preg = retire_preg_q;
  assign halt        = (state_q == RQ_HALTED);

  always_comb begin
    ent_d         = ent_q;
    preg_d        = preg_q;
    head_d        = head_q;
    tail_d        = tail_q;
    state_d       = state_q;
    retire_free_d = 1'b0;
    retire_preg_d = retire_preg_q;

    if (flush) begin
      ent_d  = '{default: '0};
      head_d = '0;
      tail_d = '0;
    end else begin
      if (done_valid && ent_q[done_tag].valid) begin
        ent_d[done_tag].done = 1'b1;
      end
      // Retire before alloc: when full no alloc happens, so slots never collide.
      if (do_retire) begin
        ent_d[head_idx].valid = 1'b0;
        ent_d[head_idx].done  = 1'b0;
        head_d                = head_q + PTR_ONE;
        retire_free_d         = head_ent.has_dst;
        if (head_ent.has_dst) begin
          retire_preg_d = preg_q[head_idx];
        end
        if (head_ent.is_halt) begin
          state_d = RQ_HALTED;
        end
      end
      if (do_alloc) begin
        ent_d[tail_idx].valid   = 1'b1;
        ent_d[tail_idx].done    = 1'b0;
        ent_d[tail_idx].has_dst = alloc_has_dst;
        ent_d[tail_idx].is_halt = alloc_is_halt;
        preg_d[tail_idx]        = alloc_old_preg;
        tail_d                  = tail_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      ent_q         <= '{default: '0};
      preg_q        <= '{default: '0};
      state_q       <= RQ_RUN;
      retire_free_q <= 1'b0;
      retire_preg_q <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      ent_q         <= ent_d;
      preg_q        <= preg_d;
      state_q       <= state_d;
      retire_free_q <= retire_free_d;
      retire_preg_q <= retire_preg_d;
    end
  end

endmodule

// File: tb/tb_retire_queue.sv
// Directed bench for retire_queue with hand-computed expectations at each step.
module tb_retire_queue;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned PREG_W = 6;
  localparam int unsigned TAG_W  = 4;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              alloc_valid;
  logic              alloc_ready;
  logic              alloc_has_dst;
  logic [PREG_W-1:0] alloc_old_preg;
  logic              alloc_is_halt;
  logic [TAG_W-1:0]  alloc_tag;
  logic              done_valid;
  logic [TAG_W-1:0]  done_tag;
  logic              flush;
  logic              retire_free;
  logic [PREG_W-1:0] retire_preg;
  logic [TAG_W:0]    count;
  logic              halt;

  int vectors     = 0;
  int miscompares = 0;
  int nret;

  retire_queue #(.DEPTH(DEPTH), .PREG_W(PREG_W)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .alloc_valid    (alloc_valid),
    .alloc_ready    (alloc_ready),
    .alloc_has_dst  (alloc_has_dst),
    .alloc_old_preg (alloc_old_preg),
    .alloc_is_halt  (alloc_is_halt),
    .alloc_tag      (alloc_tag),
    .done_valid     (done_valid),
    .done_tag       (done_tag),
    .flush          (flush),
    .retire_free    (retire_free),
    .retire_preg    (retire_preg),
    .count          (count),
    .halt           (halt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic has_dst, input logic [PREG_W-1:0] preg,
                       input logic is_halt, input logic [31:0] exp_tag);
    alloc_valid    = 1'b1;
    alloc_has_dst  = has_dst;
    alloc_old_preg = preg;
    alloc_is_halt  = is_halt;
    #1;
    check("alloc_tag", 32'(alloc_tag), exp_tag);
    check("alloc_ready", 32'(alloc_ready), 1);
    tick();
    alloc_valid = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; alloc_valid = 1'b0; alloc_has_dst = 1'b0; alloc_old_preg = '0;
    alloc_is_halt = 1'b0; done_valid = 1'b0; done_tag = '0; flush = 1'b0;
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_free", 32'(retire_free), 0);
    check("rst_preg", 32'(retire_preg), 0);
    check("rst_halt", 32'(halt), 0);
    tick();
    n_rst = 1'b1;
    #1;
    check("post_rst_ready", 32'(alloc_ready), 1);

    // Fill: 16 allocations, then a 17th that must be ignored.
    for (int i = 0; i < 16; i++) alloc(1'b1, PREG_W'(i + 32), 1'b0, 32'(i));
    alloc_valid = 1'b1; alloc_old_preg = 6'd63;
    #1;
    check("full_count", 32'(count), 16);
    check("full_ready", 32'(alloc_ready), 0);
    check("full_tag", 32'(alloc_tag), 0);
    tick();
    check("alloc17_ignored", 32'(count), 16);
    alloc_valid = 1'b0;

    // Full with head completing: allocation still blocked that cycle.
    done_valid = 1'b1; done_tag = 4'd0;
    tick();
    done_valid = 1'b0; alloc_valid = 1'b1;
    #1;
    check("full_retire_ready", 32'(alloc_ready), 0);
    check("full_retire_free0", 32'(retire_free), 0);
    tick();
    check("after_retire_count", 32'(count), 15);
    check("after_retire_ready", 32'(alloc_ready), 1);
    check("after_retire_free", 32'(retire_free), 1);
    check("after_retire_preg", 32'(retire_preg), 32);
    alloc_valid = 1'b0;
    flush = 1'b1;
    #1;
    check("flush_ready", 32'(alloc_ready), 0);
    tick();
    flush = 1'b0;
    check("flush1_count", 32'(count), 0);
    check("flush1_free", 32'(retire_free), 0);

    // In-order retire with out-of-order completion.
    alloc(1'b1, 6'd5, 1'b0, 0);
    alloc(1'b1, 6'd6, 1'b0, 1);
    alloc(1'b1, 6'd7, 1'b0, 2);
    done_valid = 1'b1; done_tag = 4'd2; tick();
    check("ooo_free_a", 32'(retire_free), 0);
    done_tag = 4'd1; tick();
    check("ooo_free_b", 32'(retire_free), 0);
    done_tag = 4'd0; tick();
    done_valid = 1'b0;
    check("ooo_free_c", 32'(retire_free), 0);
    check("ooo_count_c", 32'(count), 3);
    tick();
    check("ret0_free", 32'(retire_free), 1);
    check("ret0_preg", 32'(retire_preg), 5);
    check("ret0_count", 32'(count), 2);
    tick();
    check("ret1_free", 32'(retire_free), 1);
    check("ret1_preg", 32'(retire_preg), 6);
    tick();
    check("ret2_free", 32'(retire_free), 1);
    check("ret2_preg", 32'(retire_preg), 7);
    tick();
    check("ret_idle_free", 32'(retire_free), 0);
    check("ret_hold_preg", 32'(retire_preg), 7);
    check("ret_count", 32'(count), 0);

    // Flush with a completed head about to retire: flush wins.
    for (int i = 0; i < 5; i++) alloc(1'b1, PREG_W'(20 + i), 1'b0, 32'(3 + i));
    done_valid = 1'b1; done_tag = 4'd4; tick();
    done_tag = 4'd3; tick();
    done_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush2_count", 32'(count), 0);
    check("flush2_free", 32'(retire_free), 0);
    tick();
    check("flush2_free_late", 32'(retire_free), 0);
    alloc(1'b1, 6'd1, 1'b0, 0);
    check("flush2_realloc_count", 32'(count), 1);
    flush = 1'b1; tick(); flush = 1'b0;

    // Wrap: 20 pipelined alloc/done cycles, retire order checked via old_preg.
    nret = 0;
    for (int k = 0; k < 26; k++) begin
      alloc_valid    = (k < 20);
      alloc_has_dst  = 1'b1;
      alloc_old_preg = PREG_W'(k);
      alloc_is_halt  = 1'b0;
      done_valid     = (k >= 1 && k <= 20);
      done_tag       = TAG_W'(k - 1);
      #1;
      if (k < 20) check("wrap_tag", 32'(alloc_tag), 32'(k % 16));
      tick();
      if (retire_free) begin
        check("wrap_preg", 32'(retire_preg), 32'(nret));
        nret++;
      end
    end
    alloc_valid = 1'b0; done_valid = 1'b0;
    check("wrap_retired", 32'(nret), 20);
    check("wrap_count", 32'(count), 0);

    // HALT at tag 3, with a destination to free.
    flush = 1'b1; tick(); flush = 1'b0;
    alloc(1'b1, 6'd10, 1'b0, 0);
    alloc(1'b1, 6'd11, 1'b0, 1);
    alloc(1'b1, 6'd12, 1'b0, 2);
    alloc(1'b1, 6'd40, 1'b1, 3);
    alloc(1'b1, 6'd14, 1'b0, 4);
    done_valid = 1'b1;
    done_tag = 4'd0; tick();
    done_tag = 4'd1; tick();
    check("h_ret0_preg", 32'(retire_preg), 10);
    done_tag = 4'd2; tick();
    done_tag = 4'd3; tick();
    done_valid = 1'b0;
    check("h_ret2_preg", 32'(retire_preg), 12);
    check("h_pre_halt", 32'(halt), 0);
    tick();
    check("halt_set", 32'(halt), 1);
    check("halt_free", 32'(retire_free), 1);
    check("halt_preg", 32'(retire_preg), 40);
    check("halt_count", 32'(count), 1);
    alloc_valid = 1'b1;
    #1;
    check("halt_ready", 32'(alloc_ready), 0);
    done_valid = 1'b1; done_tag = 4'd4; tick();
    done_valid = 1'b0;
    check("halt_no_retire", 32'(retire_free), 0);
    check("halt_no_alloc", 32'(count), 1);
    tick();
    check("halt_no_retire2", 32'(retire_free), 0);
    alloc_valid = 1'b0; flush = 1'b1; tick(); flush = 1'b0;
    check("halt_sticky_flush", 32'(halt), 1);
    check("halt_ready_flush", 32'(alloc_ready), 0);

    // Reset clears HALTED; reset mid-operation discards a pending retire.
    n_rst = 1'b0;
    #1;
    check("rst2_halt", 32'(halt), 0);
    check("rst2_count", 32'(count), 0);
    tick();
    n_rst = 1'b1;
    #1;
    check("rst2_ready", 32'(alloc_ready), 1);
    alloc(1'b1, 6'd9, 1'b0, 0);
    done_valid = 1'b1; done_tag = 4'd0; tick();
    done_valid = 1'b0;
    n_rst = 1'b0;
    #1;
    check("midrst_count", 32'(count), 0);
    check("midrst_free", 32'(retire_free), 0);
    tick();
    check("midrst_free2", 32'(retire_free), 0);
    n_rst = 1'b1;
    tick();
    check("midrst_free3", 32'(retire_free), 0);
    check("midrst_count3", 32'(count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
